enable_encoder_rr: RTL and testbench
====================================

// Module: enable_encoder_rr
// PURPOSE
//  16-to-4 round-robin request encoder; inverse of the register-enable decoder.
//  Takes a 16-bit request vector (one bit per register/unit) and selects one request.
//  Presents the selected index as a registered 4-bit code on a valid/ready interface.
//  Returns a one-hot grant to the selected requester.
//  Sits between register-file/unit request lines and the shared read/writeback bus arbiter.
// PARAMETERS
//  N_REQ  16  number of requesters (fixed 16; index width follows)
//  IDX_W  4   encoded index width, clog2(N_REQ)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  req        in   16     request vector; bit i = requester i
//  out_ready  in   1      consumer accepts out_idx this cycle
//  out_valid  out  1      out_idx holds a valid selection
//  out_idx    out  4      encoded index of the selected requester
//  grant      out  16     one-hot; bit out_idx high in the handshake cycle only
//  busy       out  1      high while a selection is pending (== out_valid)
// BEHAVIOUR
//  Reset: synchronous, active-high. On rst: out_valid=0, out_idx=0, grant=0, ptr=0, state=IDLE.
//  States: IDLE (no pending selection), HOLD (selection pending, out_valid=1).
//  IDLE: if |req, select the first set bit scanning upward from ptr with wrap 15->0.
//   Register it into out_idx and go to HOLD. Latency req->out_valid = 1 clk. If req==0, stay.
//  HOLD: out_idx stable, out_valid=1 until out_valid&out_ready (handshake).
//   Requests that drop in HOLD do not retract the selection.
//  Handshake cycle: grant = 1<<out_idx (combinational from registered state; no other grant bits).
//   ptr <= (out_idx+1) mod 16 (4-bit natural wrap).
//   If req masked by ~(1<<out_idx) is nonzero, select next from new ptr, stay HOLD (back-to-back).
//   Otherwise go to IDLE with out_valid=0.
//  Requester still asserting req after grant: eligible again only after all others are scanned (fairness).
//  Rotation: ptr=15 and winner 15 gives ptr=0.
//  Single request at bit i: always won regardless of ptr.
//  out_ready while out_valid=0: ignored, grant stays 0.
//  rst mid-HOLD: pending selection discarded, no grant emitted, ptr back to 0.
//  No X/Z ever driven on outputs; grant=0 whenever out_valid=0.
// CONFIGURATION
//  ENC_FIXED_PRIO_EN defined: ptr is held at 0; lowest set index always wins (pure priority encoder).
//   Back-to-back still masks the just-granted bit for the immediate reselect.
//  Not defined: round-robin as above.
// STRUCTURE
//  Package enc_pkg: N_REQ, IDX_W localparams; state enum {IDLE, HOLD}; function onehot16(idx).
//  Sub-module rr_pick: combinational; inputs req[15:0] and ptr[3:0], outputs hit and idx[3:0].
//   Two-pass masked priority encode: req & (ones<<ptr) first, else req unmasked.
//   Instantiated once; rr_pick is the only combinational scan.
// TESTING
//  1. rst, then req=16'h0001, out_ready=1:
//     out_valid@+1 with out_idx=0; grant=16'h0001 in that cycle; next cycle out_valid=0.
//  2. req=16'h8001 held, out_ready=1:
//     out_idx sequence 0,15,0,15 back-to-back, no idle cycles; grant alternates 0001/8000.
//  3. req=16'h0010, out_ready=0 for 5 clks, then req->0:
//     out_idx=4 stable and out_valid=1 throughout; grant=0.
//     out_ready=1 -> grant=16'h0010 once.
//  4. req=16'hFFFF, out_ready=1 for 18 clks:
//     out_idx 0,1,...,15,0,1; ptr wraps.
//     With ENC_FIXED_PRIO_EN: out_idx alternates 0,1,0,1.
//  5. req=16'h0100 pending in HOLD, rst pulsed 1 clk:
//     out_valid=0, grant=0 next cycle; first selection after rst scans from ptr=0.
//  6. req=0, out_ready=1 for 10 clks:
//     out_valid=0, out_idx=0, grant=0 throughout.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared sizes, FSM state type and one-hot helper for the 16-to-4 round-robin encoder.
package enc_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot16(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin scan: lowest request at or above ptr, else lowest overall.
module rr_pick
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] masked;

  always_comb begin
    masked = req & ({N_REQ{1'b1}} << ptr);
    hit    = |req;
    idx    = '0;
    // Scan downward so the lowest set bit is the last one written.
    if (|masked) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (masked[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/enable_encoder_rr.sv
// 16-to-4 round-robin request encoder with valid/ready output and one-hot grant.
// Define ENC_FIXED_PRIO_EN to pin the scan pointer at 0 (plain priority encoder).
//
//   state | meaning
//   IDLE  | no pending selection, out_valid=0
//   HOLD  | selection in out_idx pending, out_valid=1
module enable_encoder_rr
  import enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_next;
  logic [N_REQ-1:0] pick_req;
  logic [IDX_W-1:0] pick_ptr;
  logic             pick_hit;
  logic [IDX_W-1:0] pick_idx;

  rr_pick u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  always_comb begin
    idx_next = out_idx_q + IDX_W'(1);
    pick_req = req;
    pick_ptr = ptr_q;
    // In HOLD the scan is for the back-to-back reselect: skip the winner, start past it.
    if (state_q == HOLD) begin
      pick_req = req & ~onehot16(out_idx_q);
      pick_ptr = idx_next;
    end
`ifdef ENC_FIXED_PRIO_EN
    pick_ptr = '0;
`endif

    state_d   = state_q;
    out_idx_d = out_idx_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          state_d   = HOLD;
          out_idx_d = pick_idx;
        end
      end
      HOLD: begin
        if (out_ready) begin
`ifdef ENC_FIXED_PRIO_EN
          ptr_d = '0;
`else
          ptr_d = idx_next;
`endif
          if (pick_hit) begin
            out_idx_d = pick_idx;
          end else begin
            state_d   = IDLE;
            out_idx_d = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        out_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      out_idx_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_idx_q <= out_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign busy      = out_valid;
  assign out_idx   = out_idx_q;
  assign grant     = (out_valid && out_ready) ? onehot16(out_idx_q) : '0;

endmodule

// File: tb/tb_enable_encoder_rr.sv
// Scoreboard bench for enable_encoder_rr: driver predicts each cycle's outputs, monitor compares.
module tb_enable_encoder_rr;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic [15:0] grant;
  logic        busy;

  enable_encoder_rr dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          valid;
    logic [3:0]  idx;
    logic [15:0] grant;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  // Reference model: a pending flag, the pending index and the rotation start point.
  bit   m_pend;
  int   m_idx;
  int   m_ptr;
  bit   m_known;

  function automatic int rr_sel(input logic [15:0] r, input int p);
    int j;
    for (int k = 0; k < 16; k++) begin
      j = (p + k) % 16;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  function automatic int start_ptr(input int p);
`ifdef ENC_FIXED_PRIO_EN
    return 0;
`else
    return p;
`endif
  endfunction

  task automatic step(input logic [15:0] r, input logic rdy, input logic rs);
    exp_t        e;
    logic [15:0] rest;
    @(negedge clk);
    req       = r;
    out_ready = rdy;
    rst       = rs;
    e.chk   = m_known;
    e.valid = m_pend;
    e.idx   = 4'(m_idx);
    e.grant = (m_pend && rdy) ? (16'h0001 << m_idx) : 16'h0000;
    exp_q.push_back(e);
    if (rs) begin
      m_pend  = 0;
      m_idx   = 0;
      m_ptr   = 0;
      m_known = 1;
    end else if (!m_pend) begin
      if (r != 16'h0000) begin
        m_pend = 1;
        m_idx  = rr_sel(r, start_ptr(m_ptr));
      end
    end else if (rdy) begin
      m_ptr = start_ptr((m_idx + 1) % 16);
      rest  = r & ~(16'h0001 << m_idx);
      if (rest != 16'h0000) begin
        m_idx = rr_sel(rest, m_ptr);
      end else begin
        m_pend = 0;
        m_idx  = 0;
      end
    end
  endtask

  // Monitor: compares every cycle's outputs against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          n_vec++;
          if (out_valid !== e.valid || busy !== e.valid ||
              out_idx !== e.idx || grant !== e.grant) begin
            n_err++;
            $display("FAIL cycle_out t=%0t: got valid=%b busy=%b idx=%0d grant=%h, want valid=%b idx=%0d grant=%h",
                     $time, out_valid, busy, out_idx, grant, e.valid, e.idx, e.grant);
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] r;
    logic [15:0] pat;
    int          budget;
    n_vec = 0; n_err = 0;
    m_pend = 0; m_idx = 0; m_ptr = 0; m_known = 0;
    req = '0; out_ready = 1'b0; rst = 1'b1;

    step(16'h0000, 1'b0, 1'b1);
    step(16'h0000, 1'b0, 1'b1);

    // single request, immediate accept
    step(16'h0001, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);

    // two requesters held: back-to-back alternation
    for (int i = 0; i < 6; i++) step(16'h8001, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);

    // stall with request dropping, then accept
    step(16'h0010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(16'h0000, 1'b0, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);

    // full rotation with pointer wrap
    for (int i = 0; i < 18; i++) step(16'hFFFF, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);

    // reset while a selection is pending
    step(16'h0100, 1'b0, 1'b0);
    step(16'h0100, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b1);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h8100, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);

    // idle with ready asserted
    for (int i = 0; i < 10; i++) step(16'h0000, 1'b1, 1'b0);

    // single request wins regardless of pointer position
    for (int i = 0; i < 16; i++) begin
      pat = 16'h0001 << (15 - i);
      step(pat, 1'b1, 1'b0);
      step(16'h0000, 1'b1, 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 16'($urandom);
        1:       r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2:       r = 16'h0001 << $urandom_range(0, 15);
        default: r = 16'h0000;
      endcase
      step(r, ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
